muldiv_sequencer: RTL

- Multi-cycle controller for the RV32M execute path; sequences an iterative shift-add multiplier / restoring divider datapath.
- Sits beside the EX stage. Accepts an M-extension op flagged by the decoder, latches its funct3, stalls F/D/E, and steps the datapath XLEN times.
- Drives sign-correction control, then pulses done for exactly one cycle so the result advances to MEM.

---
 rtl/muldiv_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Sequencer for the RV32M iterative multiply/divide datapath: LOAD, XLEN RUN steps, FIX, then a one-cycle DONE.
// Latency: start to done is XLEN+3 cycles, or 3 cycles for divide-by-zero (the RUN steps are skipped).
// Backpressure: holds F/D/E with a combinational stall from the cycle start is accepted until DONE; flush_e aborts.
module muldiv_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic             flush_e,
   input  logic             a_neg,
   input  logic             b_neg,
   input  logic             b_zero,
   output logic             dp_load,
   output logic             dp_step,
   output logic             dp_is_div,
   output logic             dp_signed_a,
   output logic             dp_signed_b,
   output logic             dp_sel_hi,
   output logic             dp_negate,
   output logic             dp_dbz,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RUN  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(XLEN - 1);

   state_t           state_q, state_d;
   logic [2:0]       f3_q, f3_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             dbz_q, dbz_d;
   logic [CNT_W-1:0] iter_q, iter_d;

   logic             is_div, is_rem, signed_a, signed_b, sel_hi;

   // Operation class decoded from the latched funct3.
   always_comb begin
      is_div   = f3_q[2];
      is_rem   = f3_q[2] & f3_q[1];
      signed_a = (f3_q == 3'b001) | (f3_q == 3'b010) | (f3_q == 3'b100) | (f3_q == 3'b110);
      signed_b = (f3_q == 3'b001) | (f3_q == 3'b100) | (f3_q == 3'b110);
      sel_hi   = (f3_q == 3'b001) | (f3_q == 3'b010) | (f3_q == 3'b011) | f3_q[1] & f3_q[2];
   end

   // Next state, operand latching and the iteration counter.
   always_comb begin
      state_d = state_q;
      f3_d    = f3_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dbz_d   = dbz_q;
      iter_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (start && !flush_e) begin
               f3_d    = funct3;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // Sign flags only matter for operands treated as signed.
            sa_d  = a_neg & signed_a;
            sb_d  = b_neg & signed_b;
            dbz_d = is_div & b_zero;
            if (flush_e)
               state_d = S_IDLE;
            else if (is_div && b_zero)
               state_d = S_FIX;
            else
               state_d = S_RUN;
         end
         S_RUN: begin
            if (flush_e) begin
               state_d = S_IDLE;
            end else if (iter_q == ITER_LAST) begin
               state_d = S_FIX;
            end else begin
               iter_d = iter_q + 1'b1;
            end
         end
         S_FIX: begin
            state_d = flush_e ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            // Result is handed over regardless of flush; any start here is dropped.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched-field registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         f3_q    <= 3'b000;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dbz_q   <= 1'b0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dbz_q   <= dbz_d;
         iter_q  <= iter_d;
      end
   end

   // Datapath controls decoded from the state and latched fields.
   always_comb begin
      dp_load     = (state_q == S_LOAD);
      dp_step     = (state_q == S_RUN);
      dp_is_div   = is_div;
      dp_signed_a = signed_a;
      dp_signed_b = signed_b;
      dp_sel_hi   = sel_hi;
      dp_negate   = (state_q == S_FIX) & ~dbz_q & (is_rem ? sa_q : (sa_q ^ sb_q));
      dp_dbz      = (state_q == S_FIX) & dbz_q;
      stall       = ((state_q == S_IDLE) & start & ~flush_e) |
                    (state_q == S_LOAD) | (state_q == S_RUN) | (state_q == S_FIX);
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE);
      iter        = iter_q;
   end

endmodule
